// File: rtl/pipe_trace_buffer_if.sv
// Bus bundle for pipe_trace_buffer: capture controls, stage snapshots, readback and status.
interface pipe_trace_buffer_if #(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_W    = 32,
    parameter int PTR_W      = 4
);
    logic                          arm;
    logic                          trigIn;
    logic [NUM_STAGES-1:0]         stageValid;
    logic [NUM_STAGES*STAGE_W-1:0] stageData;
    logic [PTR_W-1:0]              rdAddr;
    logic [NUM_STAGES*STAGE_W-1:0] rdData;
    logic                          rdValid;
    logic [1:0]                    state;
    logic [PTR_W-1:0]              trigPtr;
    logic [PTR_W:0]                count;

    modport master (
        output arm, trigIn, stageValid, stageData, rdAddr,
        input  rdData, rdValid, state, trigPtr, count
    );

    modport slave (
        input  arm, trigIn, stageValid, stageData, rdAddr,
        output rdData, rdValid, state, trigPtr, count
    );
endinterface

// File: rtl/pipe_trace_buffer.sv
// Circular trace buffer of masked pipeline-stage snapshots, frozen a fixed window after a trigger.
// Optional macro TRACE_DEDUP_EN: skip writing an entry identical to the last one written.
module pipe_trace_buffer #(
    parameter int NUM_STAGES = 4,
    parameter int STAGE_W    = 32,
    parameter int DEPTH      = 16,
    parameter int PTR_W      = 4,
    parameter int POST_TRIG  = 8
) (
    input logic              Clk,
    input logic              Rst_n,
    pipe_trace_buffer_if.slave bus
);
    localparam int ENTRY_W = NUM_STAGES * STAGE_W;
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_POST  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [PTR_W:0]   FULL      = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W-1:0] POST_INIT = PTR_W'(POST_TRIG);

    logic [ENTRY_W-1:0] mem [DEPTH];

    logic [1:0]         state_q;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   post_cnt;
    logic [PTR_W-1:0]   trig_slot;
    logic [PTR_W:0]     cnt;
    logic [ENTRY_W-1:0] entry;
    logic [ENTRY_W-1:0] rd_data_p1;
    logic               rd_vld_p1;
    logic               capturing;
    logic               qual;
    logic               trig_hit;
    logic               dup;
    logic               wr_en;
    logic [PTR_W-1:0]   oldest;
    logic [PTR_W-1:0]   rd_phys;

    // Invalid stage slices are stored as zero bubbles
    always_comb begin
        entry = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (bus.stageValid[i])
                entry[i*STAGE_W +: STAGE_W] = bus.stageData[i*STAGE_W +: STAGE_W];
        end
    end

    assign capturing = (state_q == S_ARMED) || (state_q == S_POST);
    assign qual      = |bus.stageValid;
    assign trig_hit  = (state_q == S_ARMED) && bus.trigIn && !bus.arm;

`ifdef TRACE_DEDUP_EN
    logic [ENTRY_W-1:0] last_entry;
    logic               have_last;

    assign dup = have_last && (entry == last_entry) && !trig_hit;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            have_last <= 1'b0;
        else if (bus.arm)
            have_last <= 1'b0;
        else if (wr_en)
            have_last <= 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (wr_en)
            last_entry <= entry;
    end
`else
    assign dup = 1'b0;
`endif

    // The trigger entry is written even when no stage is valid
    assign wr_en = capturing && !bus.arm && (qual || trig_hit) && !dup;

    always_ff @(posedge Clk) begin
        if (wr_en)
            mem[wr_ptr] <= entry;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_IDLE;
            wr_ptr    <= '0;
            cnt       <= '0;
            post_cnt  <= '0;
            trig_slot <= '0;
        end else if (bus.arm) begin
            state_q  <= S_ARMED;
            wr_ptr   <= '0;
            cnt      <= '0;
            post_cnt <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            if (cnt != FULL)
                cnt <= cnt + 1'b1;
            if (trig_hit) begin
                trig_slot <= wr_ptr;
                if (POST_TRIG == 0) begin
                    state_q <= S_DONE;
                end else begin
                    state_q  <= S_POST;
                    post_cnt <= POST_INIT;
                end
            end else if (state_q == S_POST) begin
                post_cnt <= post_cnt - 1'b1;
                if (post_cnt == PTR_W'(1))
                    state_q <= S_DONE;
            end
        end
    end

    // Logical index 0 maps to the oldest surviving entry; wrap is implicit in PTR_W arithmetic
    assign oldest  = wr_ptr - cnt[PTR_W-1:0];
    assign rd_phys = oldest + bus.rdAddr;

    // ---- read stage p1 ----
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_data_p1 <= '0;
            rd_vld_p1  <= 1'b0;
        end else if ((state_q == S_DONE) && ({1'b0, bus.rdAddr} < cnt)) begin
            rd_data_p1 <= mem[rd_phys];
            rd_vld_p1  <= 1'b1;
        end else begin
            rd_data_p1 <= '0;
            rd_vld_p1  <= 1'b0;
        end
    end

    assign bus.rdData  = rd_data_p1;
    assign bus.rdValid = rd_vld_p1;
    assign bus.state   = state_q;
    assign bus.trigPtr = trig_slot - oldest;
    assign bus.count   = cnt;
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Self-checking bench for pipe_trace_buffer: capture/trigger/wrap/mask/arm/reset and readback scoreboard.
module tb_pipe_trace_buffer;
    localparam int NS = 4;
    localparam int SW = 32;
    localparam int PW = 4;
    localparam int W  = NS * SW;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    typedef struct {
        logic [PW-1:0] addr;
        logic [W-1:0]  data;
        logic          vld;
    } rd_vec_t;

    rd_vec_t     rtab[13];
    logic [W:0]  sb[$];

    pipe_trace_buffer_if #(.NUM_STAGES(NS), .STAGE_W(SW), .PTR_W(PW)) bus ();

    pipe_trace_buffer #(
        .NUM_STAGES(NS), .STAGE_W(SW), .DEPTH(16), .PTR_W(PW), .POST_TRIG(8)
    ) dut (
        .Clk  (clk),
        .Rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic [3:0] v, input logic [31:0] d, input logic t, input logic a);
        bus.stageValid = v;
        bus.stageData  = {4{d}};
        bus.trigIn     = t;
        bus.arm        = a;
        @(posedge clk);
        #1;
        bus.arm        = 1'b0;
        bus.trigIn     = 1'b0;
        bus.stageValid = '0;
    endtask

    task automatic rd(input string name, input logic [PW-1:0] addr, input logic [W-1:0] d, input logic v);
        logic [W:0] e;
        bus.rdAddr = addr;
        sb.push_back({v, d});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({name, "_vld"}, W'(bus.rdValid), W'(e[W]));
        chk({name, "_data"}, bus.rdData, e[W-1:0]);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.arm = 1'b0;
        bus.trigIn = 1'b0;
        bus.stageValid = '0;
        bus.stageData = '0;
        bus.rdAddr = '0;

        for (int i = 0; i < 11; i++) begin
            rtab[i].addr = PW'(i);
            rtab[i].data = {4{32'(i + 1)}};
            rtab[i].vld  = 1'b1;
        end
        rtab[11] = '{addr: 4'd11, data: '0, vld: 1'b0};
        rtab[12] = '{addr: 4'd15, data: '0, vld: 1'b0};

        // Reset state
        #12;
        chk("rst_state", W'(bus.state), W'(0));
        chk("rst_count", W'(bus.count), W'(0));
        chk("rst_trigptr", W'(bus.trigPtr), W'(0));
        chk("rst_rdvalid", W'(bus.rdValid), W'(0));
        chk("rst_rddata", bus.rdData, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic capture: 1..11, bubble cycle skipped, trigger on data 3
        cyc(4'h0, 32'd0, 1'b0, 1'b1);
        chk("arm_state", W'(bus.state), W'(1));
        cyc(4'hF, 32'd1, 1'b0, 1'b0);
        cyc(4'h0, 32'd99, 1'b0, 1'b0);
        chk("bubble_count", W'(bus.count), W'(1));
        cyc(4'hF, 32'd2, 1'b0, 1'b0);
        cyc(4'hF, 32'd3, 1'b1, 1'b0);
        chk("trig_state", W'(bus.state), W'(2));
        for (int d = 4; d <= 10; d++) cyc(4'hF, 32'(d), 1'b0, 1'b0);
        chk("post_state", W'(bus.state), W'(2));
        cyc(4'hF, 32'd11, 1'b0, 1'b0);
        chk("a_done", W'(bus.state), W'(3));
        chk("a_count", W'(bus.count), W'(11));
        chk("a_trigptr", W'(bus.trigPtr), W'(2));
        cyc(4'hF, 32'd77, 1'b1, 1'b0);
        chk("done_nowrite", W'(bus.count), W'(11));
        foreach (rtab[i]) rd($sformatf("a_rd%0d", i), rtab[i].addr, rtab[i].data, rtab[i].vld);

        // Wrap: 0..39, trigger at 30, freeze at 38
        cyc(4'h0, 32'd0, 1'b0, 1'b1);
        for (int d = 0; d < 40; d++) begin
            cyc(4'hF, 32'(d), (d == 30), 1'b0);
            if (d == 37) chk("b_post37", W'(bus.state), W'(2));
            if (d == 38) chk("b_done38", W'(bus.state), W'(3));
        end
        chk("b_count", W'(bus.count), W'(16));
        chk("b_trigptr", W'(bus.trigPtr), W'(7));
        rd("b_rd0", 4'd0, {4{32'd23}}, 1'b1);
        rd("b_rd7", 4'd7, {4{32'd30}}, 1'b1);
        rd("b_rd15", 4'd15, {4{32'd38}}, 1'b1);

        // Bubbles, arm priority, arm during POST
        cyc(4'h0, 32'd0, 1'b0, 1'b1);
        cyc(4'h0, 32'd5, 1'b0, 1'b0);
        chk("c_nowrite", W'(bus.count), W'(0));
        cyc(4'h0, 32'd5, 1'b1, 1'b0);
        chk("c_trig0_count", W'(bus.count), W'(1));
        chk("c_trig0_state", W'(bus.state), W'(2));
        cyc(4'h0, 32'd0, 1'b0, 1'b1);
        cyc(4'hF, 32'd4, 1'b1, 1'b1);
        chk("c_armtrig_state", W'(bus.state), W'(1));
        chk("c_armtrig_count", W'(bus.count), W'(0));
        cyc(4'h5, 32'hFFFF_FFFF, 1'b1, 1'b0);
        chk("c_post_state", W'(bus.state), W'(2));
        cyc(4'h0, 32'd0, 1'b0, 1'b1);
        chk("c_rearm_state", W'(bus.state), W'(1));
        chk("c_rearm_count", W'(bus.count), W'(0));

        // Masked slices
        cyc(4'h5, 32'hFFFF_FFFF, 1'b1, 1'b0);
        for (int d = 1; d <= 8; d++) cyc(4'hF, 32'(d), 1'b0, 1'b0);
        chk("d_done", W'(bus.state), W'(3));
        chk("d_count", W'(bus.count), W'(9));
        rd("d_rd0", 4'd0, {32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF}, 1'b1);
        rd("d_rd1", 4'd1, {4{32'd1}}, 1'b1);

        // Asynchronous reset in the middle of POST
        cyc(4'h0, 32'd0, 1'b0, 1'b1);
        cyc(4'hF, 32'd5, 1'b1, 1'b0);
        cyc(4'hF, 32'd6, 1'b0, 1'b0);
        chk("e_pre_state", W'(bus.state), W'(2));
        #3;
        rst_n = 1'b0;
        #1;
        chk("e_rst_state", W'(bus.state), W'(0));
        chk("e_rst_count", W'(bus.count), W'(0));
        chk("e_rst_rdvalid", W'(bus.rdValid), W'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Repeated entries
        cyc(4'h0, 32'd0, 1'b0, 1'b1);
        cyc(4'hF, 32'd7, 1'b0, 1'b0);
        cyc(4'hF, 32'd7, 1'b0, 1'b0);
        cyc(4'hF, 32'd7, 1'b0, 1'b0);
        cyc(4'hF, 32'd8, 1'b0, 1'b0);
`ifdef TRACE_DEDUP_EN
        chk("f_count_pre", W'(bus.count), W'(2));
        cyc(4'hF, 32'd8, 1'b1, 1'b0);
        chk("f_count_trig", W'(bus.count), W'(3));
`else
        chk("f_count_pre", W'(bus.count), W'(4));
        cyc(4'hF, 32'd8, 1'b1, 1'b0);
        chk("f_count_trig", W'(bus.count), W'(5));
`endif
        chk("f_state", W'(bus.state), W'(2));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
- Synthesizable on-chip trace capture for the pipelined processor.
- Snapshots up to NUM_STAGES pipeline-register buses (IF/ID/EX/MEM payloads) each qualifying cycle into a circular buffer.
- Freezes a programmable number of entries after a trigger; contents are read back oldest-first once frozen.
- Generalises the per-negedge stage dump to N stages, arbitrary width/depth, trigger and post-trigger window.

Parameters:
- NUM_STAGES, 4, number of monitored pipeline stages.
- STAGE_W, 32, payload bits per stage.
- DEPTH, 16, buffer entries; power of 2, >= 4.
- PTR_W, 4, log2(DEPTH).
- POST_TRIG, 8, entries captured after the trigger entry; must be < DEPTH.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- arm  in  1  start/restart capture, single-cycle pulse.
- trigIn  in  1  trigger condition.
- stageValid  in  NUM_STAGES  per-stage valid; bit i qualifies slice i.
- stageData  in  NUM_STAGES*STAGE_W  concatenated stage payloads; stage 0 in the LSBs.
- rdAddr  in  PTR_W  logical read index; 0 = oldest entry.
- rdData  out  NUM_STAGES*STAGE_W  read entry, registered.
- rdValid  out  1  rdData holds a valid entry.
- state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE.
- trigPtr  out  PTR_W  logical index of the trigger entry (valid in DONE).
- count  out  PTR_W+1  number of stored entries, saturating at DEPTH.

Behaviour:
- Reset (async, Rst_n=0):
  - state=IDLE.
  - wrPtr, count, postCnt, trigPtr, rdData and rdValid all 0.
  - Memory contents are don't-care.
- Qualifying cycle: |stageValid = 1.
- Entry format: each stage slice i is stored as stageData slice i if stageValid[i], else 0 (bubble).
- IDLE: no capture.
  - arm -> ARMED; clears wrPtr, count and postCnt.
- ARMED: each qualifying cycle:
  - Write entry at wrPtr.
  - wrPtr <= wrPtr+1, wrapping DEPTH-1 -> 0.
  - count <= min(count+1, DEPTH).
- ARMED with trigIn=1: the trigger cycle's entry is always written, even if all stageValid=0 (writes an all-zero entry).
  - Record physical trigger slot.
  - POST_TRIG=0 -> DONE; else -> POST with postCnt=POST_TRIG.
- POST: capture continues as in ARMED.
  - postCnt decrements per written entry.
  - The write that takes postCnt from 1 to 0 -> DONE, on the same edge.
  - trigIn is ignored.
- DONE: no writes; trigIn ignored.
  - trigPtr = (trigSlot - (wrPtr - count)) mod DEPTH.
- arm priority:
  - arm in any state restarts to ARMED with counters cleared; the arm cycle itself is not captured.
  - arm and trigIn in the same cycle: arm wins, trigger dropped.
- Readback (1-cycle latency):
  - Physical address = (wrPtr - count + rdAddr) mod DEPTH.
  - Next cycle: rdData = entry and rdValid=1, if state==DONE and rdAddr < count.
  - Otherwise rdData=0 and rdValid=0.
- Wrap: when count==DEPTH, the oldest entry is overwritten and the logical window slides; trigPtr remains correct.

Optional Feature:
TRACE_DEDUP_EN:
- Defined: in ARMED/POST, a qualifying cycle whose masked entry equals the last written entry is not written (no pointer, count or postCnt change).
  - The first entry after arm is always written.
  - The trigger-cycle entry is always written.
- Undefined: every qualifying cycle is written; no comparison register is built.

Test Plan:
- Reset mid-POST (Rst_n low for 1 ns, asynchronous) -> state=0, count=0, rdValid=0 immediately.
- Arm; 5 qualifying cycles with data 1..5; trigIn on the 3rd; POST_TRIG=2 -> DONE after the 5th; count=5, trigPtr=2; rdAddr 0..4 returns 1..5 one cycle later with rdValid=1.
- DEPTH=16, POST_TRIG=8: 40 qualifying cycles with data 0..39, trigger at data 30 -> DONE at data 38; count=16; rdAddr 0 = 23, rdAddr 15 = 38; trigPtr=7.
- stageValid=4'b0101 with all slices 0xFFFFFFFF -> stored entry has slices 1 and 3 = 0; stageValid=0 cycles are not written unless trigIn=1.
- arm and trigIn in the same cycle -> state=ARMED, no trigger; arm during POST -> ARMED, count=0.
- TRACE_DEDUP_EN: data sequence 7,7,7,8 -> count=2 before trigger; trigger on a repeated 8 -> written, count=3.
